// File: rtl/zbt_pkg.sv
// Shared widths, pipeline depth and encodings for the ZBT port arbiter.
package zbt_pkg;

  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 36;
  // Cycles between the address phase and the data phase of a ZBT access.
  localparam int ZBT_LAT = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_RD  = 2'd1,
    OP_WR  = 2'd2
  } op_e;

endpackage

// File: rtl/zbt_rr_arb2.sv
// Two-way round-robin arbiter; the requester granted last loses the next tie.
module zbt_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // prio_q low favours requester 0 on a tie.
  logic prio_q;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q <= 1'b0;
    end else if (|gnt_o) begin
      prio_q <= gnt_o[0];
    end
  end

endmodule

// File: rtl/zbt_port_arbiter.sv
// Shares one ZBT SRAM between a point writer and a readback engine, hides the
// pipelined data phase, and provides a self-timed clear sweep.
module zbt_port_arbiter
  import zbt_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = 19'd524287
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clear_start,
  output logic              busy,
  output logic              overflow,
  output logic [ADDR_W-1:0] max_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we_b,
  output logic [DATA_W-1:0] ram_data_out,
  output logic              ram_data_oe,
  input  logic [DATA_W-1:0] ram_data_in
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0] max_addr_q;
  logic              overflow_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_b_q;
  logic [DATA_W-1:0] ram_data_out_q;
  logic              ram_data_oe_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  op_e               op_pipe_q   [ZBT_LAT+1];
  logic [DATA_W-1:0] data_pipe_q [ZBT_LAT];

  logic [1:0]        gnt;
  logic              arb_en;
  logic              clear_go;
  logic              wr_over;
  op_e               issue_op;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_data;

  // Widened compare so the check stays meaningful when the limit is all-ones.
  assign wr_over  = {1'b0, wr_addr} > {1'b0, ADDR_LIMIT};
  assign clear_go = (state_q == IDLE) && clear_start;
  assign arb_en   = (state_q == IDLE) && !clear_start;

  zbt_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req_i ({rd_req, wr_req}),
    .en_i  (arb_en),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    issue_op   = OP_NOP;
    issue_addr = ram_addr_q;
    issue_data = '0;
    case (state_q)
      IDLE: begin
        if (clear_go) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end else if (gnt[0] && !wr_over) begin
          issue_op   = OP_WR;
          issue_addr = wr_addr;
          issue_data = wr_data;
        end else if (gnt[1]) begin
          issue_op   = OP_RD;
          issue_addr = rd_addr;
        end
      end
      CLEAR: begin
        issue_op   = OP_WR;
        issue_addr = clr_addr_q;
        if (clr_addr_q == ADDR_LIMIT) begin
          state_d = IDLE;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      clr_addr_q <= '0;
      max_addr_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      if (clear_go) begin
        max_addr_q <= '0;
        overflow_q <= 1'b0;
      end else if (gnt[0]) begin
        if (wr_over) begin
          overflow_q <= 1'b1;
        end else if (wr_addr > max_addr_q) begin
          max_addr_q <= wr_addr;
        end
      end
    end
  end

  // Address phase, then the op type rides a shift register to its data phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_addr_q     <= '0;
      ram_we_b_q     <= 1'b1;
      ram_data_out_q <= '0;
      ram_data_oe_q  <= 1'b0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      for (int i = 0; i <= ZBT_LAT; i++) op_pipe_q[i] <= OP_NOP;
      for (int i = 0; i < ZBT_LAT; i++) data_pipe_q[i] <= '0;
    end else begin
      ram_addr_q     <= issue_addr;
      ram_we_b_q     <= (issue_op != OP_WR);
      op_pipe_q[0]   <= issue_op;
      data_pipe_q[0] <= issue_data;
      for (int i = 1; i <= ZBT_LAT; i++) op_pipe_q[i] <= op_pipe_q[i-1];
      for (int i = 1; i < ZBT_LAT; i++) data_pipe_q[i] <= data_pipe_q[i-1];
      ram_data_oe_q  <= (op_pipe_q[ZBT_LAT-1] == OP_WR);
      ram_data_out_q <= (op_pipe_q[ZBT_LAT-1] == OP_WR) ? data_pipe_q[ZBT_LAT-1] : '0;
      rd_valid_q     <= (op_pipe_q[ZBT_LAT] == OP_RD);
      if (op_pipe_q[ZBT_LAT] == OP_RD) begin
        rd_data_q <= ram_data_in;
      end
    end
  end

  assign wr_ack       = gnt[0];
  assign rd_ack       = gnt[1];
  assign busy         = (state_q == CLEAR);
  assign overflow     = overflow_q;
  assign max_addr     = max_addr_q;
  assign ram_addr     = ram_addr_q;
  assign ram_we_b     = ram_we_b_q;
  assign ram_data_out = ram_data_out_q;
  assign ram_data_oe  = ram_data_oe_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;

endmodule

// File: tb/tb_zbt_port_arbiter.sv
// Directed bench for zbt_port_arbiter with hand-computed expectations.
module tb_zbt_port_arbiter;
  import zbt_pkg::*;

  localparam logic [ADDR_W-1:0] LIMIT = 19'd15;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wr_req, rd_req, clear_start;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data, ram_data_in;
  logic              wr_ack, rd_ack, rd_valid, busy, overflow;
  logic              ram_we_b, ram_data_oe;
  logic [DATA_W-1:0] rd_data, ram_data_out;
  logic [ADDR_W-1:0] max_addr, ram_addr;

  int compareCount  = 0;
  int mismatchCount = 0;

  always #5 clk = ~clk;

  zbt_port_arbiter #(.ADDR_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_ack       (rd_ack),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .clear_start  (clear_start),
    .busy         (busy),
    .overflow     (overflow),
    .max_addr     (max_addr),
    .ram_addr     (ram_addr),
    .ram_we_b     (ram_we_b),
    .ram_data_out (ram_data_out),
    .ram_data_oe  (ram_data_oe),
    .ram_data_in  (ram_data_in)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expected);
    compareCount++;
    if (got !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                               input logic rd, input logic [ADDR_W-1:0] ra, input logic clr);
    wr_req      = wr;
    wr_addr     = wa;
    wr_data     = wd;
    rd_req      = rd;
    rd_addr     = ra;
    clear_start = clr;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ram_addr"}, 64'(ram_addr), 64'h0);
    checkOutput({tag, "_we_b"}, 64'(ram_we_b), 64'h1);
    checkOutput({tag, "_dout"}, 64'(ram_data_out), 64'h0);
    checkOutput({tag, "_oe"}, 64'(ram_data_oe), 64'h0);
    checkOutput({tag, "_rd_data"}, 64'(rd_data), 64'h0);
    checkOutput({tag, "_rd_valid"}, 64'(rd_valid), 64'h0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'h0);
    checkOutput({tag, "_overflow"}, 64'(overflow), 64'h0);
    checkOutput({tag, "_max_addr"}, 64'(max_addr), 64'h0);
  endtask

  task automatic applyReset();
    reset = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    ram_data_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    ram_data_in = '0;
    repeat (2) @(negedge clk);
    checkResetValues("rst");
    reset = 1'b1;
    @(negedge clk);

    // Single write: grant in C, address phase C+1, data phase C+3.
    applyStimulus(1'b1, 19'd5, 36'hABC, 1'b0, '0, 1'b0);
    #1 checkOutput("w1_ack", 64'(wr_ack), 64'h1);
    checkOutput("w1_rdack", 64'(rd_ack), 64'h0);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    #1 checkOutput("w1_addr", 64'(ram_addr), 64'h5);
    checkOutput("w1_we_b", 64'(ram_we_b), 64'h0);
    checkOutput("w1_oe_c1", 64'(ram_data_oe), 64'h0);
    checkOutput("w1_max", 64'(max_addr), 64'h5);
    @(negedge clk);
    #1 checkOutput("w1_we_b_c2", 64'(ram_we_b), 64'h1);
    checkOutput("w1_oe_c2", 64'(ram_data_oe), 64'h0);
    @(negedge clk);
    #1 checkOutput("w1_oe_c3", 64'(ram_data_oe), 64'h1);
    checkOutput("w1_dout_c3", 64'(ram_data_out), 64'hABC);
    @(negedge clk);
    #1 checkOutput("w1_oe_c4", 64'(ram_data_oe), 64'h0);
    repeat (2) @(negedge clk);

    // Single read: data presented in C+3, returned with one strobe in C+4.
    applyStimulus(1'b0, '0, '0, 1'b1, 19'd5, 1'b0);
    #1 checkOutput("r1_ack", 64'(rd_ack), 64'h1);
    checkOutput("r1_wrack", 64'(wr_ack), 64'h0);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    #1 checkOutput("r1_addr", 64'(ram_addr), 64'h5);
    checkOutput("r1_we_b", 64'(ram_we_b), 64'h1);
    @(negedge clk);
    #1 checkOutput("r1_valid_c2", 64'(rd_valid), 64'h0);
    @(negedge clk);
    ram_data_in = 36'h123;
    #1 checkOutput("r1_valid_c3", 64'(rd_valid), 64'h0);
    checkOutput("r1_oe_c3", 64'(ram_data_oe), 64'h0);
    @(negedge clk);
    ram_data_in = 36'h0;
    #1 checkOutput("r1_valid_c4", 64'(rd_valid), 64'h1);
    checkOutput("r1_data_c4", 64'(rd_data), 64'h123);
    @(negedge clk);
    #1 checkOutput("r1_valid_c5", 64'(rd_valid), 64'h0);
    @(negedge clk);
    #1 checkOutput("r1_valid_c6", 64'(rd_valid), 64'h0);

    // Contending requesters alternate, writer first after reset.
    applyReset();
    @(negedge clk);
    applyStimulus(1'b1, 19'd7, 36'h77, 1'b1, 19'd3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      #1 checkOutput($sformatf("rr_wack%0d", i), 64'(wr_ack), 64'(i % 2 == 0));
      checkOutput($sformatf("rr_rack%0d", i), 64'(rd_ack), 64'(i % 2 == 1));
      if (i > 0) begin
        checkOutput($sformatf("rr_we_b%0d", i), 64'(ram_we_b), 64'(i % 2 == 0));
        checkOutput($sformatf("rr_addr%0d", i), 64'(ram_addr), (i % 2 == 1) ? 64'h7 : 64'h3);
      end
      @(negedge clk);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    #1 checkOutput("rr_max", 64'(max_addr), 64'h7);
    repeat (4) @(negedge clk);

    // Out-of-range write is acknowledged and dropped.
    applyStimulus(1'b1, 19'd20, 36'h999, 1'b0, '0, 1'b0);
    #1 checkOutput("ov_ack", 64'(wr_ack), 64'h1);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    #1 checkOutput("ov_we_b", 64'(ram_we_b), 64'h1);
    checkOutput("ov_flag", 64'(overflow), 64'h1);
    checkOutput("ov_max", 64'(max_addr), 64'h7);
    repeat (2) @(negedge clk);
    #1 checkOutput("ov_oe", 64'(ram_data_oe), 64'h0);
    @(negedge clk);

    // Clear sweep with a writer waiting throughout.
    applyStimulus(1'b1, 19'd2, 36'h5, 1'b0, '0, 1'b1);
    #1 checkOutput("cl_ack_start", 64'(wr_ack), 64'h0);
    checkOutput("cl_busy_start", 64'(busy), 64'h0);
    @(negedge clk);
    clear_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1 checkOutput($sformatf("cl_busy%0d", k), 64'(busy), 64'h1);
      checkOutput($sformatf("cl_ack%0d", k), 64'(wr_ack), 64'h0);
      if (k == 0) begin
        checkOutput("cl_max", 64'(max_addr), 64'h0);
        checkOutput("cl_ovf", 64'(overflow), 64'h0);
      end
      if (k > 0) begin
        checkOutput($sformatf("cl_addr%0d", k), 64'(ram_addr), 64'(k - 1));
        checkOutput($sformatf("cl_we_b%0d", k), 64'(ram_we_b), 64'h0);
      end
      if (k > 2) begin
        checkOutput($sformatf("cl_oe%0d", k), 64'(ram_data_oe), 64'h1);
        checkOutput($sformatf("cl_dout%0d", k), 64'(ram_data_out), 64'h0);
      end
      @(negedge clk);
    end
    #1 checkOutput("cl_busy_end", 64'(busy), 64'h0);
    checkOutput("cl_ack_end", 64'(wr_ack), 64'h1);
    checkOutput("cl_addr_last", 64'(ram_addr), 64'hF);
    checkOutput("cl_we_b_last", 64'(ram_we_b), 64'h0);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    #1 checkOutput("cl_wr_addr", 64'(ram_addr), 64'h2);
    checkOutput("cl_wr_we_b", 64'(ram_we_b), 64'h0);
    checkOutput("cl_wr_max", 64'(max_addr), 64'h2);
    repeat (4) @(negedge clk);

    // Reset during in-flight write and read discards both.
    applyStimulus(1'b1, 19'd11, 36'hDEF, 1'b0, '0, 1'b0);
    #1 checkOutput("mr_wack", 64'(wr_ack), 64'h1);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, 1'b1, 19'd9, 1'b0);
    #1 checkOutput("mr_rack", 64'(rd_ack), 64'h1);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    #1 checkOutput("mr_oe_pre", 64'(ram_data_oe), 64'h1);
    checkOutput("mr_dout_pre", 64'(ram_data_out), 64'hDEF);
    reset = 1'b0;
    #1 checkResetValues("mr");
    repeat (2) @(negedge clk);
    ram_data_in = 36'h777;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 checkOutput($sformatf("mr_valid%0d", k), 64'(rd_valid), 64'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
